// File: rtl/i2s_pkg.sv
// Shared I2S definitions: controller state encoding and lrclk channel values.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } i2s_ctrl_state_t;

  localparam logic I2S_CH_L = 1'b0;
  localparam logic I2S_CH_R = 1'b1;

endpackage : i2s_pkg

// File: rtl/i2s_sclk_div.sv
// Bit-clock divider: toggles sclk every SCLK_DIV/2 enabled cycles and flags
// the edge being driven this cycle through rise/fall strobes.
module i2s_sclk_div #(
  parameter int unsigned SCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic sclk_o,
  output logic rise_c_o,
  output logic fall_c_o
);

  localparam int unsigned H  = SCLK_DIV / 2;
  localparam int unsigned DW = (H > 1) ? $clog2(H) : 1;
  localparam logic [DW-1:0] CNT_LAST = DW'(H - 1);

  logic [DW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          tick_c;

  always_comb begin
    tick_c = en_i && !clr_i && (cnt_q == CNT_LAST);
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (clr_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (en_i) begin
      if (tick_c) begin
        cnt_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        cnt_d = cnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o   = sclk_q;
  assign rise_c_o = tick_c && !sclk_q;
  assign fall_c_o = tick_c && sclk_q;

endmodule : i2s_sclk_div

// File: rtl/i2s_ctrl.sv
// I2S bus master: generates sclk/lrclk, starts/stops on frame boundaries,
// counts frames and flags underruns on the I2STx sample stream.
module i2s_ctrl
  import i2s_pkg::*;
#(
  parameter int unsigned SCLK_DIV    = 4,
  parameter int unsigned BITS_PER_CH = 32,
  parameter int unsigned CNTW        = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            clr_stats,
  input  logic            mon_tvalid,
  input  logic            mon_tready,
  output logic            sclk,
  output logic            lrclk,
  output logic            running,
  output logic            frame_start,
  output logic [CNTW-1:0] frame_count,
  output logic            underrun,
  output logic [CNTW-1:0] underrun_count
);

  localparam int unsigned BW = $clog2(2 * BITS_PER_CH);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * BITS_PER_CH - 1);
  localparam logic [BW-1:0] BIT_HALF = BW'(BITS_PER_CH - 1);

  if (SCLK_DIV < 2 || (SCLK_DIV % 2) != 0) begin : g_bad_sclk_div
    $error("i2s_ctrl: SCLK_DIV must be even and >= 2");
  end
  if (BITS_PER_CH < 2) begin : g_bad_bits_per_ch
    $error("i2s_ctrl: BITS_PER_CH must be >= 2");
  end

  i2s_ctrl_state_t state_q, state_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic            lrclk_q, lrclk_d;
  logic            running_q, running_d;
  logic            fs_q, fs_d;
  logic            ur_q, ur_d;
  logic [CNTW-1:0] fcnt_q, fcnt_d;
  logic [CNTW-1:0] ucnt_q, ucnt_d;
  logic [1:0]      smp_q, smp_d;
  logic            first_q, first_d;

  logic div_clr_c, sclk_fall_c, sclk_rise_unused_c;
  logic hs_c, bit_last_c, stop_c;

  assign div_clr_c = (state_q == IDLE);

  i2s_sclk_div #(
    .SCLK_DIV(SCLK_DIV)
  ) u_sclk_div (
    .clk     (clk),
    .rst     (rst),
    .en_i    (1'b1),
    .clr_i   (div_clr_c),
    .sclk_o  (sclk),
    .rise_c_o(sclk_rise_unused_c),
    .fall_c_o(sclk_fall_c)
  );

  // Next-state, bit counter, lrclk and statistics.
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    lrclk_d    = lrclk_q;
    fs_d       = 1'b0;
    ur_d       = 1'b0;
    fcnt_d     = fcnt_q;
    ucnt_d     = ucnt_q;
    smp_d      = smp_q;
    first_d    = first_q;
    hs_c       = mon_tvalid && mon_tready;
    bit_last_c = (bit_q == BIT_LAST);
    stop_c     = (state_q == STOPPING) && !enable && sclk_fall_c && bit_last_c;

    unique case (state_q)
      IDLE:     if (enable) state_d = RUN;
      RUN:      if (!enable) state_d = STOPPING;
      STOPPING: begin
        if (enable)      state_d = RUN;
        else if (stop_c) state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase

    if (hs_c && smp_q != 2'd3) smp_d = smp_q + 2'd1;

    if (state_q == IDLE || stop_c) begin
      bit_d   = BIT_LAST;
      lrclk_d = I2S_CH_R;
      smp_d   = 2'd0;
      first_d = 1'b1;
    end else if (sclk_fall_c) begin
      if (bit_last_c) begin
        bit_d   = '0;
        lrclk_d = I2S_CH_L;
        fs_d    = 1'b1;
        fcnt_d  = fcnt_q + CNTW'(1);
        smp_d   = hs_c ? 2'd1 : 2'd0;
        first_d = 1'b0;
        // The frame opened right after IDLE has no previous frame to judge.
        if (!first_q && smp_q < 2'd2) begin
          ur_d = 1'b1;
          if (ucnt_q != '1) ucnt_d = ucnt_q + CNTW'(1);
        end
      end else begin
        bit_d = bit_q + BW'(1);
        if (bit_q == BIT_HALF) lrclk_d = I2S_CH_R;
      end
    end

    if (clr_stats) begin
      fcnt_d = '0;
      ucnt_d = '0;
    end

    running_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_q     <= BIT_LAST;
      lrclk_q   <= I2S_CH_R;
      running_q <= 1'b0;
      fs_q      <= 1'b0;
      ur_q      <= 1'b0;
      fcnt_q    <= '0;
      ucnt_q    <= '0;
      smp_q     <= 2'd0;
      first_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      lrclk_q   <= lrclk_d;
      running_q <= running_d;
      fs_q      <= fs_d;
      ur_q      <= ur_d;
      fcnt_q    <= fcnt_d;
      ucnt_q    <= ucnt_d;
      smp_q     <= smp_d;
      first_q   <= first_d;
    end
  end

  assign lrclk          = lrclk_q;
  assign running        = running_q;
  assign frame_start    = fs_q;
  assign underrun       = ur_q;
  assign frame_count    = fcnt_q;
  assign underrun_count = ucnt_q;

endmodule : i2s_ctrl

// File: tb/tb_i2s_ctrl.sv
// Directed bench for i2s_ctrl (SCLK_DIV=4, BITS_PER_CH=4, CNTW=2; 32-cycle frames).
module tb_i2s_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       clr_stats = 1'b0;
  logic       mon_tvalid = 1'b0;
  logic       mon_tready = 1'b0;
  logic       sclk, lrclk, running, frame_start, underrun;
  logic [1:0] frame_count, underrun_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  i2s_ctrl #(
    .SCLK_DIV   (4),
    .BITS_PER_CH(4),
    .CNTW       (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .clr_stats     (clr_stats),
    .mon_tvalid    (mon_tvalid),
    .mon_tready    (mon_tready),
    .sclk          (sclk),
    .lrclk         (lrclk),
    .running       (running),
    .frame_start   (frame_start),
    .frame_count   (frame_count),
    .underrun      (underrun),
    .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go(input int target);
    while (cyc < target) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s @cyc %0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic hs_at(input int c);
    go(c);
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    go(c + 1);
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sclk"},  32'(sclk), 32'd0);
    chk({tag, "_lrclk"}, 32'(lrclk), 32'd1);
    chk({tag, "_run"},   32'(running), 32'd0);
    chk({tag, "_fs"},    32'(frame_start), 32'd0);
    chk({tag, "_fcnt"},  32'(frame_count), 32'd0);
    chk({tag, "_ur"},    32'(underrun), 32'd0);
    chk({tag, "_ucnt"},  32'(underrun_count), 32'd0);
  endtask

  initial begin
    // Reset
    tick();
    tick();
    chk_reset_vals("rst");
    rst    = 1'b0;
    cyc    = 0;
    enable = 1'b1;

    // Start-up timing
    go(1);   chk("start_running", 32'(running), 32'd1);
             chk("start_sclk_c1", 32'(sclk), 32'd0);
    go(2);   chk("start_sclk_c2", 32'(sclk), 32'd0);
    go(3);   chk("first_sclk_rise", 32'(sclk), 32'd1);
    go(4);   chk("fs_not_yet", 32'(frame_start), 32'd0);
    go(5);   chk("first_lrclk_fall", 32'(lrclk), 32'd0);
             chk("first_fs", 32'(frame_start), 32'd1);
             chk("first_fcnt", 32'(frame_count), 32'd1);
             chk("first_no_ur", 32'(underrun), 32'd0);
    go(6);   chk("fs_one_cycle", 32'(frame_start), 32'd0);

    // Frame 1: two handshakes
    hs_at(10);
    hs_at(12);
    go(20);  chk("lrclk_left", 32'(lrclk), 32'd0);
    go(21);  chk("lrclk_rise", 32'(lrclk), 32'd1);
    go(37);  chk("f2_fs", 32'(frame_start), 32'd1);
             chk("f2_lrclk", 32'(lrclk), 32'd0);
             chk("f2_fcnt", 32'(frame_count), 32'd2);
             chk("f2_no_ur", 32'(underrun), 32'd0);

    // Frame 2: one handshake; one more coincident with frame-3 start counts for frame 3
    hs_at(40);
    hs_at(68);
    go(69);  chk("f3_ur", 32'(underrun), 32'd1);
             chk("f3_ucnt", 32'(underrun_count), 32'd1);
             chk("f3_fcnt", 32'(frame_count), 32'd3);
    go(70);  chk("ur_one_cycle", 32'(underrun), 32'd0);
    hs_at(80);
    go(101); chk("f4_no_ur", 32'(underrun), 32'd0);
             chk("f4_ucnt", 32'(underrun_count), 32'd1);
             chk("fcnt_wrap", 32'(frame_count), 32'd0);

    // clr_stats coincident with an underrun
    go(132); clr_stats = 1'b1;
    go(133); clr_stats = 1'b0;
             chk("clr_ur_pulse", 32'(underrun), 32'd1);
             chk("clr_ucnt", 32'(underrun_count), 32'd0);
             chk("clr_fcnt", 32'(frame_count), 32'd0);

    // Stop mid-frame
    go(140); enable = 1'b0;
    go(141); chk("stopping_running", 32'(running), 32'd1);
    go(147); chk("stopping_sclk", 32'(sclk), 32'd1);
    go(164); chk("pre_stop_sclk", 32'(sclk), 32'd1);
             chk("pre_stop_run", 32'(running), 32'd1);
    go(165); chk("stop_sclk", 32'(sclk), 32'd0);
             chk("stop_lrclk", 32'(lrclk), 32'd1);
             chk("stop_running", 32'(running), 32'd0);
             chk("stop_no_fs", 32'(frame_start), 32'd0);
    go(169); chk("idle_sclk", 32'(sclk), 32'd0);
             chk("idle_fcnt", 32'(frame_count), 32'd0);

    // Restart, then re-enable during STOPPING
    go(170); enable = 1'b1;
    go(171); chk("restart_running", 32'(running), 32'd1);
    go(175); chk("restart_fs", 32'(frame_start), 32'd1);
             chk("restart_no_ur", 32'(underrun), 32'd0);
             chk("restart_fcnt", 32'(frame_count), 32'd1);
    go(180); enable = 1'b0;
    go(185); chk("stp2_sclk_hi", 32'(sclk), 32'd1);
             chk("stp2_running", 32'(running), 32'd1);
    go(187); chk("stp2_sclk_lo", 32'(sclk), 32'd0);
    go(190); enable = 1'b1;
    go(193); chk("resume_sclk_hi", 32'(sclk), 32'd1);
    go(195); chk("resume_sclk_lo", 32'(sclk), 32'd0);
    go(207); chk("resume_fs", 32'(frame_start), 32'd1);
             chk("resume_lrclk", 32'(lrclk), 32'd0);
             chk("resume_running", 32'(running), 32'd1);
             chk("resume_fcnt", 32'(frame_count), 32'd2);
             chk("starve1_ur", 32'(underrun), 32'd1);
             chk("starve1_ucnt", 32'(underrun_count), 32'd1);

    // Saturation of underrun_count
    go(271); chk("starve3_ucnt", 32'(underrun_count), 32'd3);
             chk("fcnt_wrap2", 32'(frame_count), 32'd0);
    go(303); chk("starve4_ur", 32'(underrun), 32'd1);
             chk("starve4_ucnt_sat", 32'(underrun_count), 32'd3);
    go(335); chk("starve5_ucnt_sat", 32'(underrun_count), 32'd3);

    // Reset mid-RUN on an sclk rising edge
    go(336); rst = 1'b1;
    go(337); chk_reset_vals("midrst");
             rst = 1'b0;
    go(341); chk("post_rst_no_fs", 32'(frame_start), 32'd0);
    go(342); chk("post_rst_fs", 32'(frame_start), 32'd1);
             chk("post_rst_fcnt", 32'(frame_count), 32'd1);
             chk("post_rst_running", 32'(running), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_i2s_ctrl
